// File: rtl/gf180mcu_fd_sc_mcu7t5v0__dlytap_ctrl.sv
// Delay-tap selector controller.
// Walks a registered tap pointer one index at a time toward a requested
// target, waiting SETTLE cycles after every step so the external delay
// chain output settles, then pulses TAP_ACK for one cycle.
// Optional feature: define DLYTAP_LOCK_EN to add a LOCK input that blocks
// new requests while idle.
module gf180mcu_fd_sc_mcu7t5v0__dlytap_ctrl #(
  parameter int unsigned NTAP      = 8,
  parameter int unsigned TW        = 3,
  parameter int unsigned SETTLE    = 4,
  parameter int unsigned RESET_TAP = 0
) (
  input  logic            CLK,
  input  logic            RN,
  input  logic [NTAP-1:0] TAPS,
  input  logic            TAP_REQ,
  input  logic [TW-1:0]   TAP_SEL,
`ifdef DLYTAP_LOCK_EN
  input  logic            LOCK,
`endif
  output logic            Z,
  output logic [TW-1:0]   TAP_CUR,
  output logic            BUSY,
  output logic            TAP_ACK
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] STEP = 2'd1;
  localparam logic [1:0] SETL = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [TW-1:0] TAP_MAX  = TW'(NTAP - 1);
  localparam logic [TW-1:0] TAP_RST  = TW'(RESET_TAP);
  localparam logic [TW-1:0] TAP_ONE  = TW'(1);
  localparam logic [3:0]    CNT_LOAD = 4'(SETTLE);

  logic [1:0]    state, state_next;
  logic [TW-1:0] target, target_next;
  logic [TW-1:0] cur_next;
  logic [3:0]    cnt, cnt_next;
  logic          accept;
  logic [TW-1:0] sel_clamped;

  // Request qualification and target clamping to the last real tap
  always_comb begin
`ifdef DLYTAP_LOCK_EN
    accept = TAP_REQ && !LOCK;
`else
    accept = TAP_REQ;
`endif
    sel_clamped = (TAP_SEL > TAP_MAX) ? TAP_MAX : TAP_SEL;
  end

  // Next-state logic: accept, single-step, settle, acknowledge
  always_comb begin
    state_next  = state;
    target_next = target;
    cur_next    = TAP_CUR;
    cnt_next    = cnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
          target_next = sel_clamped;
          state_next  = (sel_clamped == TAP_CUR) ? DONE : STEP;
        end
      end
      STEP: begin
        // Target never leaves 0..NTAP-1, so stepping toward it cannot wrap
        if (TAP_CUR < target) begin
          cur_next = TAP_CUR + TAP_ONE;
        end else if (TAP_CUR > target) begin
          cur_next = TAP_CUR - TAP_ONE;
        end
        cnt_next   = CNT_LOAD;
        state_next = SETL;
      end
      SETL: begin
        cnt_next = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          state_next = (TAP_CUR != target) ? STEP : DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State registers with asynchronous abort to the reset tap
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state   <= IDLE;
      TAP_CUR <= TAP_RST;
      target  <= TAP_RST;
      cnt     <= 4'd0;
    end else begin
      state   <= state_next;
      TAP_CUR <= cur_next;
      target  <= target_next;
      cnt     <= cnt_next;
    end
  end

  // Outputs: tap mux driven only by the registered pointer
  always_comb begin
    Z       = TAPS[TAP_CUR];
    BUSY    = (state != IDLE);
    TAP_ACK = (state == DONE);
  end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__dlytap_ctrl.sv
// Directed bench for the delay-tap controller (NTAP=6, SETTLE=4, RESET_TAP=0).
// Build with DLYTAP_LOCK_EN defined to also exercise the LOCK input.
module tb_gf180mcu_fd_sc_mcu7t5v0__dlytap_ctrl;

  localparam int NTAP = 6;
  localparam int S    = 4;

  logic            clk;
  logic            rn;
  logic [NTAP-1:0] taps;
  logic            tap_req;
  logic [2:0]      tap_sel;
  logic            lock;
  logic            z;
  logic [2:0]      tap_cur;
  logic            busy;
  logic            tap_ack;

  int n_cmp = 0;
  int n_bad = 0;

  gf180mcu_fd_sc_mcu7t5v0__dlytap_ctrl #(
    .NTAP(NTAP), .TW(3), .SETTLE(S), .RESET_TAP(0)
  ) dut (
    .CLK(clk),
    .RN(rn),
    .TAPS(taps),
    .TAP_REQ(tap_req),
    .TAP_SEL(tap_sel),
`ifdef DLYTAP_LOCK_EN
    .LOCK(lock),
`endif
    .Z(z),
    .TAP_CUR(tap_cur),
    .BUSY(busy),
    .TAP_ACK(tap_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and check every cycle until the controller is idle again.
  // Expected pointer after edge k+i: start + dir*min(d, (i-1)/(1+S)+1).
  task automatic run_move(input int sel, input int start, input int tgt,
                          input int poke_at, input int lock_at, input string name);
    int d;
    int dir;
    int dd;
    int pos;
    logic [2:0] e_cur;
    logic e_ack;
    logic e_busy;
    dir = (tgt >= start) ? 1 : -1;
    d = (tgt >= start) ? (tgt - start) : (start - tgt);
    dd = d * (1 + S);
    tap_sel = 3'(sel);
    tap_req = 1'b1;
    tick();
    tap_req = 1'b0;
    tap_sel = 3'd0;
    for (int i = 0; i <= dd + 1; i++) begin
      if (i == 0) pos = start;
      else begin
        pos = (i - 1) / (1 + S) + 1;
        if (pos > d) pos = d;
        pos = start + dir * pos;
      end
      e_cur = 3'(pos);
      e_ack = (i == dd);
      e_busy = (i <= dd);
      n_cmp++;
      if (tap_cur !== e_cur) begin
        n_bad++;
        $display("FAIL %s tap_cur i=%0d: got %0d want %0d", name, i, tap_cur, e_cur);
      end
      n_cmp++;
      if (tap_ack !== e_ack) begin
        n_bad++;
        $display("FAIL %s tap_ack i=%0d: got %b want %b", name, i, tap_ack, e_ack);
      end
      n_cmp++;
      if (busy !== e_busy) begin
        n_bad++;
        $display("FAIL %s busy i=%0d: got %b want %b", name, i, busy, e_busy);
      end
      n_cmp++;
      if (z !== taps[e_cur]) begin
        n_bad++;
        $display("FAIL %s z i=%0d: got %b want %b", name, i, z, taps[e_cur]);
      end
      if (i <= dd) begin
        if (i == poke_at) begin
          tap_req = 1'b1;
          tap_sel = 3'd0;
        end
        if (i == lock_at) lock = 1'b1;
        tick();
        tap_req = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rn = 1'b0;
    tap_req = 1'b0;
    tap_sel = 3'd0;
    lock = 1'b0;
    taps = 6'b101100;
    tick();
    tick();
    n_cmp++;
    if (tap_cur !== 3'd0) begin
      n_bad++;
      $display("FAIL reset tap_cur: got %0d want 0", tap_cur);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset busy: got %b want 0", busy);
    end
    n_cmp++;
    if (tap_ack !== 1'b0) begin
      n_bad++;
      $display("FAIL reset tap_ack: got %b want 0", tap_ack);
    end
    n_cmp++;
    if (z !== 1'b0) begin
      n_bad++;
      $display("FAIL reset z: got %b want 0", z);
    end
    rn = 1'b1;
  endtask

  // First request right after reset release: steps on k+1, k+6, k+11, ack after k+15
  task automatic test_move_up();
    run_move(3, 0, 3, -1, -1, "up_0_to_3");
  endtask

  task automatic test_same_tap();
    run_move(3, 3, 3, -1, -1, "same_3");
  endtask

  task automatic test_move_down();
    run_move(5, 3, 5, -1, -1, "up_3_to_5");
    run_move(1, 5, 1, -1, -1, "down_5_to_1");
  endtask

  // TAP_SEL=7 clamps to 5; a request poked while busy must be dropped
  task automatic test_clamp();
    run_move(7, 1, 5, 3, -1, "clamp_7");
    tick();
    tick();
    n_cmp++;
    if (busy !== 1'b0 || tap_cur !== 3'd5) begin
      n_bad++;
      $display("FAIL ignored_req: got busy=%b cur=%0d want busy=0 cur=5", busy, tap_cur);
    end
  endtask

  // Request held through DONE is re-accepted on the first idle edge
  task automatic test_back_to_back();
    logic exp_ack[4];
    exp_ack = '{1'b1, 1'b0, 1'b1, 1'b0};
    tap_sel = 3'd5;
    tap_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (tap_ack !== exp_ack[i]) begin
        n_bad++;
        $display("FAIL b2b ack cyc=%0d: got %b want %b", i, tap_ack, exp_ack[i]);
      end
    end
    tap_req = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (busy !== 1'b0 || tap_ack !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b idle: got busy=%b ack=%b want 0 0", busy, tap_ack);
    end
  endtask

  task automatic test_reset_mid_move();
    tap_sel = 3'd2;
    tap_req = 1'b1;
    tick();
    tap_req = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    n_cmp++;
    if (tap_cur !== 3'd3 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_move pre: got cur=%0d busy=%b want 3 1", tap_cur, busy);
    end
    rn = 1'b0;
    #1;
    n_cmp++;
    if (tap_cur !== 3'd0 || busy !== 1'b0 || tap_ack !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: got cur=%0d busy=%b ack=%b want 0 0 0",
               tap_cur, busy, tap_ack);
    end
    #1;
    rn = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      n_cmp++;
      if (tap_ack !== 1'b0 || busy !== 1'b0 || tap_cur !== 3'd0) begin
        n_bad++;
        $display("FAIL abort cyc=%0d: got ack=%b busy=%b cur=%0d want 0 0 0",
                 i, tap_ack, busy, tap_cur);
      end
    end
  endtask

  // Z is a pure mux of TAPS at the current pointer
  task automatic test_z_mux();
    run_move(4, 0, 4, -1, -1, "up_0_to_4");
    taps = 6'b010000;
    #1;
    n_cmp++;
    if (z !== 1'b1) begin
      n_bad++;
      $display("FAIL z_mux_hi: got %b want 1", z);
    end
    taps = 6'b101111;
    #1;
    n_cmp++;
    if (z !== 1'b0) begin
      n_bad++;
      $display("FAIL z_mux_lo: got %b want 0", z);
    end
    taps = 6'b101100;
  endtask

`ifdef DLYTAP_LOCK_EN
  task automatic test_lock();
    lock = 1'b1;
    tap_sel = 3'd1;
    tap_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (busy !== 1'b0 || tap_cur !== 3'd4) begin
        n_bad++;
        $display("FAIL lock_block cyc=%0d: got busy=%b cur=%0d want 0 4", i, busy, tap_cur);
      end
    end
    tap_req = 1'b0;
    lock = 1'b0;
    run_move(2, 4, 2, -1, 2, "lock_mid_move");
    lock = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_move_up();
    test_same_tap();
    test_move_down();
    test_clamp();
    test_back_to_back();
    test_reset_mid_move();
    test_z_mux();
`ifdef DLYTAP_LOCK_EN
    test_lock();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
